main_memory: RTL and testbench

Line-granular main-memory model that sits directly downstream of the data cache and serves its refill and write-back traffic over the 256-bit memory bus. Accepts one request at a time, holds it for a fixed programmable latency, then commits the write or returns the read line with a one-cycle acknowledge pulse. Used as the off-chip memory behind the CPU in system simulation and as the cache's reference partner in unit benches.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/main_memory_array.sv | 40 ++++
 rtl/main_memory.sv | 102 ++++++++++
 tb/tb_main_memory.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// mem_pkg -- constants and state type shared by main_memory and the cache controller.
// Rev 1.0 -- initial release.
package mem_pkg;

  localparam int LINE_W          = 256;
  localparam int OFFSET_W        = 5;
  localparam int DEFAULT_LATENCY = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

  // A latency of 1 still needs a one-bit counter.
  function automatic int cnt_width(input int latency);
    return (latency > 1) ? $clog2(latency) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/main_memory_array.sv
`default_nettype none
// main_memory_array -- single-port DEPTH x LINE_W line store, synchronous write, registered read.
// Rev 1.0 -- initial release.
module main_memory_array #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem_array [DEPTH];
  logic [LINE_W-1:0] rdata_q, rdata_d;

  // Read register holds its value until the next read commit.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_array[idx_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  // Contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_array[idx_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// main_memory -- one-request-at-a-time line memory with fixed programmable latency.
// Rev 1.0 -- initial release.
module main_memory #(
  parameter int LINE_W  = mem_pkg::LINE_W,
  parameter int DEPTH   = 512,
  parameter int LATENCY = mem_pkg::DEFAULT_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  import mem_pkg::*;

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam int              CNT_W    = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              mem_we, mem_re;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{addr_i[31:OFFSET_W+IDX_W], addr_i[OFFSET_W-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[OFFSET_W +: IDX_W];
          wdata_d = data_i;
          write_d = write_i;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ACK;
          // Gated by reset so an abort on the commit edge leaves the line intact.
          mem_we  = write_q & rst_i;
          mem_re  = ~write_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
  end

  main_memory_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// tb_main_memory -- randomized self-checking bench against a line-array reference model.
// Rev 1.0 -- initial release.
module tb_main_memory;

  localparam int LAT   = 10;
  localparam int DEPTH = 512;
  localparam int LW    = 256;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic          enable_i;
  logic          write_i;
  logic          ack_o;
  logic [LW-1:0] data_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [LW-1:0] model [int];
  int            written_q[$];
  logic [LW-1:0] last_rd;

  main_memory #(
    .LINE_W  (LW),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd32) % 32'(DEPTH));
  endfunction

  // Issues one request from an IDLE cycle and returns after the following IDLE cycle.
  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wdata,
                           input bit scramble, output logic [LW-1:0] rdata, output int lat,
                           output bit busy_ok, output bit post_ok);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = wdata;
    @(posedge clk); #1;
    enable_i = 1'b0;
    busy_ok  = 1'b1;
    lat      = 0;
    while (ack_o !== 1'b1 && lat < 40) begin
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (scramble) begin
        enable_i = 1'($urandom);
        write_i  = 1'($urandom);
        addr_i   = $urandom;
        data_i   = rand_line();
      end
      @(posedge clk); #1;
      lat++;
    end
    enable_i = 1'b0;
    rdata    = data_o;
    if (busy_o !== 1'b1) busy_ok = 1'b0;
    @(posedge clk); #1;
    post_ok = (ack_o === 1'b0) && (busy_o === 1'b0);
    if (wr) begin
      model[line_of(addr)] = wdata;
      written_q.push_back(line_of(addr));
    end
  endtask

  task automatic test_reset();
    rst_i    = 1'b0;
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h60;
    data_i   = '1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (ack_o !== 1'b0 || busy_o !== 1'b0 || data_o !== '0) begin
        errors++;
        $display("FAIL reset_outputs ack=%b busy=%b data_o=%h required ack=0 busy=0 data_o=0",
                 ack_o, busy_o, data_o);
      end
    end
    enable_i = 1'b0;
    rst_i    = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (busy_o !== 1'b0 || ack_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_access busy=%b ack=%b required busy=0 ack=0", busy_o, ack_o);
      end
    end
  endtask

  task automatic test_read_latency();
    logic [LW-1:0] pat, rd;
    int lat;
    bit bz, post;
    pat = {8{32'hDEADBEEF}};
    do_access(1'b1, 32'h200, pat, 1'b0, rd, lat, bz, post);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL write_latency got=%0d required=%0d", lat, LAT);
    end
    do_access(1'b0, 32'h200, '0, 1'b0, rd, lat, bz, post);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL read_latency got=%0d required=%0d", lat, LAT);
    end
    checks++;
    if (rd !== pat) begin
      errors++;
      $display("FAIL read_data got=%h required=%h", rd, pat);
    end
    checks++;
    if (!bz || !post) begin
      errors++;
      $display("FAIL read_busy_window busy_ok=%b post_idle_ok=%b required 1 1", bz, post);
    end
  endtask

  task automatic test_write_read();
    logic [LW-1:0] exp, rd, other;
    int lat;
    bit bz, post;
    exp = LW'(8'hAA);
    do_access(1'b1, 32'h41F, exp, 1'b0, rd, lat, bz, post);
    do_access(1'b0, 32'h400, '0, 1'b0, rd, lat, bz, post);
    checks++;
    if (rd !== exp) begin
      errors++;
      $display("FAIL offset_ignored got=%h required=%h", rd, exp);
    end
    other = rand_line();
    do_access(1'b1, 32'h1000, other, 1'b0, rd, lat, bz, post);
    checks++;
    if (rd !== exp || data_o !== exp) begin
      errors++;
      $display("FAIL data_hold_on_write ack_data=%h idle_data=%h required=%h", rd, data_o, exp);
    end
  endtask

  task automatic test_midflight();
    logic [31:0]   a;
    logic [LW-1:0] d, rd;
    int lat;
    bit bz, post;
    for (int n = 0; n < 3; n++) begin
      a = $urandom;
      d = rand_line();
      do_access(1'b1, a, d, 1'b1, rd, lat, bz, post);
      checks++;
      if (lat != LAT || !bz || !post) begin
        errors++;
        $display("FAIL midflight_write_timing lat=%0d busy_ok=%b post_ok=%b required lat=%0d 1 1",
                 lat, bz, post, LAT);
      end
      do_access(1'b0, a, '0, 1'b1, rd, lat, bz, post);
      checks++;
      if (rd !== model[line_of(a)]) begin
        errors++;
        $display("FAIL midflight_data got=%h required=%h", rd, model[line_of(a)]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [LW-1:0] v1, v2, rd;
    int lat;
    bit bz, post;
    v1 = rand_line();
    v2 = ~v1;
    do_access(1'b1, 32'h60, v1, 1'b0, rd, lat, bz, post);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h60;
    data_i   = v2;
    @(posedge clk); #1;
    enable_i = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || ack_o !== 1'b0 || data_o !== '0) begin
      errors++;
      $display("FAIL reset_abort busy=%b ack=%b data_o=%h required busy=0 ack=0 data_o=0",
               busy_o, ack_o, data_o);
    end
    rst_i = 1'b1;
    repeat (LAT + 2) begin
      @(posedge clk); #1;
    end
    do_access(1'b0, 32'h60, '0, 1'b0, rd, lat, bz, post);
    checks++;
    if (rd !== v1) begin
      errors++;
      $display("FAIL aborted_write_committed got=%h required=%h", rd, v1);
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] x, rd;
    logic [LW-1:0] d[2];
    int            t[2];
    int            n, k, lat;
    bit            bz, post;
    logic          gap_busy;
    x        = rand_line();
    n        = 0;
    k        = 0;
    gap_busy = 1'bx;
    do_access(1'b1, 32'h0, x, 1'b0, rd, lat, bz, post);
    enable_i = 1'b1;
    write_i  = 1'b0;
    addr_i   = 32'h4000;
    while (n < 2 && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (ack_o === 1'b1) begin
        t[n] = cyc;
        d[n] = data_o;
        n++;
        if (n == 1) begin
          @(posedge clk); #1;
          k++;
          gap_busy = busy_o;
        end
      end
    end
    enable_i = 1'b0;
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL b2b_ack_count got=%0d required=2", n);
    end else begin
      checks++;
      if (t[1] - t[0] != LAT + 2) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d required=%0d", t[1] - t[0], LAT + 2);
      end
      checks++;
      if (d[0] !== x || d[1] !== x) begin
        errors++;
        $display("FAIL b2b_wrap_data first=%h second=%h required=%h", d[0], d[1], x);
      end
    end
    checks++;
    if (gap_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap busy=%b required=0", gap_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_idle busy=%b required=0", busy_o);
    end
    last_rd = x;
  endtask

  task automatic test_random();
    logic [31:0]   a;
    logic [LW-1:0] d, rd, exp;
    int            lat, idx;
    bit            bz, post, wr;
    for (int n = 0; n < 24; n++) begin
      wr = (n != 0) && ($urandom_range(0, 1) == 1);
      if (wr) begin
        a = $urandom;
        d = rand_line();
        do_access(1'b1, a, d, 1'b0, rd, lat, bz, post);
        checks++;
        if (rd !== last_rd) begin
          errors++;
          $display("FAIL rand_write_data_o_changed got=%h required=%h", rd, last_rd);
        end
      end else begin
        idx = written_q[$urandom_range(0, written_q.size() - 1)];
        a   = ($urandom & 32'hFFFF_C01F) | (32'(idx) << 5);
        exp = model[idx];
        do_access(1'b0, a, '0, 1'b0, rd, lat, bz, post);
        checks++;
        if (rd !== exp) begin
          errors++;
          $display("FAIL rand_read addr=%h got=%h required=%h", a, rd, exp);
        end
        last_rd = exp;
      end
      checks++;
      if (lat != LAT || !bz || !post) begin
        errors++;
        $display("FAIL rand_timing lat=%0d busy_ok=%b post_ok=%b required lat=%0d 1 1",
                 lat, bz, post, LAT);
      end
    end
  endtask

  initial begin
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    rst_i    = 1'b0;
    last_rd  = '0;
    test_reset();
    test_read_latency();
    test_write_read();
    test_midflight();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
